move_check_unit: RTL and testbench

- Collision checker for the falling tetromino in the game-logic block.
- On a run pulse it captures a requested move (left, right, down, rotate, appear) and the current block descriptor.
- It tests the candidate shape and position against the occupancy map of the playfield, including its walls.
- After a fixed latency it reports whether the move is legal and the position delta to apply.

---
 rtl/move_check_unit.sv | 159 +++++++++++++++
 tb/tb_move_check_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_check_unit.sv
// Collision checker for the falling tetromino: tests a requested move against the playfield occupancy map.
// Define MOVE_CHECK_SINGLE_CYCLE_EN to evaluate all 16 mask cells in one cycle instead of a four-row scan.
module move_check_unit #(
   parameter int FIELD_ROW_CNT = 20,
   parameter int FIELD_COL_CNT = 10,
   parameter int EXT_ROW_CNT   = FIELD_ROW_CNT + 2,
   parameter int EXT_COL_CNT   = FIELD_COL_CNT + 2,
   parameter int X_W           = 5,
   parameter int Y_W           = 6
) (
   input  logic                                 clk_i,
   input  logic                                 rst_n_i,
   input  logic                                 run_i,
   input  logic [2:0]                           req_move_i,
   input  logic [63:0]                          block_i_data,
   input  logic [1:0]                           block_i_rotation,
   input  logic signed [X_W-1:0]                block_i_x,
   input  logic signed [Y_W-1:0]                block_i_y,
   input  logic [EXT_ROW_CNT*EXT_COL_CNT-1:0]   field_i,
   output logic                                 done_o,
   output logic                                 can_move_o,
   output logic signed [1:0]                    move_x_o,
   output logic signed [1:0]                    move_y_o
);

   localparam int CX_W       = X_W + 2;
   localparam int CY_W       = Y_W + 2;
   localparam int FIELD_BITS = EXT_ROW_CNT * EXT_COL_CNT;
   localparam int IDX_W      = $clog2(FIELD_BITS);

   localparam logic [2:0] MV_LEFT   = 3'd0;
   localparam logic [2:0] MV_RIGHT  = 3'd1;
   localparam logic [2:0] MV_ROTATE = 3'd3;
   localparam logic [2:0] MV_APPEAR = 3'd4;

   localparam logic signed [CX_W-1:0] COL_LIM = CX_W'(EXT_COL_CNT);
   localparam logic signed [CY_W-1:0] ROW_LIM = CY_W'(EXT_ROW_CNT);

   typedef enum logic {ST_IDLE, ST_SCAN} state_e;

   state_e                   state_q, state_d;
   logic [3:0][3:0]          mask_q;
   logic signed [CX_W-1:0]   x_q;
   logic signed [CY_W-1:0]   y_q;
   logic signed [1:0]        dx_q, dy_q;
   logic [1:0]               row_q;
   logic                     hit_q;

   logic [3:0][15:0]         rot_masks;
   logic [1:0]               rot_sel;
   logic signed [1:0]        dx_in, dy_in;
   logic                     scan_hit, scan_last;

   assign rot_masks = block_i_data;

   // Move decode at capture time; codes 5..7 fall through to DOWN.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      dx_in   = 2'sd0;
      dy_in   = 2'sd0;
      rot_sel = block_i_rotation;
      case (req_move_i)
         MV_LEFT:   dx_in = -2'sd1;
         MV_RIGHT:  dx_in = 2'sd1;
         MV_ROTATE: rot_sel = block_i_rotation + 2'd1;
         MV_APPEAR: ;
         default:   dy_in = 2'sd1;
      endcase
   end

   // Cells outside the side walls or below the floor collide; cells above the field never do.
   function automatic logic cell_hit(input logic signed [CY_W-1:0] row,
                                     input logic signed [CX_W-1:0] col);
      logic [IDX_W-1:0] idx;
      logic             hit;
      idx = IDX_W'(int'(row) * EXT_COL_CNT + int'(col));
      if (col[CX_W-1] || col >= COL_LIM)      hit = 1'b1;
      else if (row >= ROW_LIM)                hit = 1'b1;
      else if (row[CY_W-1])                   hit = 1'b0;
      else                                    hit = field_i[idx];
      return hit;
   endfunction

`ifdef MOVE_CHECK_SINGLE_CYCLE_EN
   always_comb begin
      scan_hit  = 1'b0;
      scan_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (mask_q[3-i][3-j] && cell_hit(y_q + CY_W'(i), x_q + CX_W'(j)))
               scan_hit = 1'b1;
         end
      end
   end
`else
   // Mask row row_q sits in slice 3-row_q; column j is bit 3-j of that slice.
   always_comb begin
      scan_hit  = 1'b0;
      scan_last = (row_q == 2'd3);
      for (int j = 0; j < 4; j++) begin
         if (mask_q[2'd3 - row_q][3-j] && cell_hit(y_q + CY_W'(row_q), x_q + CX_W'(j)))
            scan_hit = 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (run_i) state_d = ST_SCAN;
         ST_SCAN: if (!run_i && scan_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: capture registers are reset too, so nothing downstream ever sees X after reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mask_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         row_q      <= '0;
         hit_q      <= 1'b0;
         done_o     <= 1'b0;
         can_move_o <= 1'b0;
         move_x_o   <= '0;
         move_y_o   <= '0;
      end else begin
         done_o <= 1'b0;
         if (run_i) begin
            // A new run always wins, silently aborting any scan in flight.
            mask_q <= rot_masks[2'd3 - rot_sel];
            x_q    <= CX_W'(block_i_x) + CX_W'(dx_in);
            y_q    <= CY_W'(block_i_y) + CY_W'(dy_in);
            dx_q   <= dx_in;
            dy_q   <= dy_in;
            row_q  <= '0;
            hit_q  <= 1'b0;
         end else if (state_q == ST_SCAN) begin
            hit_q <= hit_q | scan_hit;
            row_q <= row_q + 2'd1;
            if (scan_last) begin
               done_o     <= 1'b1;
               can_move_o <= !(hit_q | scan_hit);
               move_x_o   <= dx_q;
               move_y_o   <= dy_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_move_check_unit.sv
// Self-checking bench for move_check_unit: directed scenarios plus randomized moves against a rule-level model.
module tb_move_check_unit;

   localparam int ER  = 22;
   localparam int EC  = 12;
   localparam int X_W = 5;
   localparam int Y_W = 6;
`ifdef MOVE_CHECK_SINGLE_CYCLE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 4;
`endif

   logic                  clk_i = 1'b0;
   logic                  rst_n_i;
   logic                  run_i;
   logic [2:0]            req_move_i;
   logic [63:0]           block_i_data;
   logic [1:0]            block_i_rotation;
   logic signed [X_W-1:0] block_i_x;
   logic signed [Y_W-1:0] block_i_y;
   logic [ER*EC-1:0]      field;
   logic                  done_o;
   logic                  can_move_o;
   logic signed [1:0]     move_x_o;
   logic signed [1:0]     move_y_o;

   int check_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk_i = ~clk_i;

   move_check_unit dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .run_i            (run_i),
      .req_move_i       (req_move_i),
      .block_i_data     (block_i_data),
      .block_i_rotation (block_i_rotation),
      .block_i_x        (block_i_x),
      .block_i_y        (block_i_y),
      .field_i          (field),
      .done_o           (done_o),
      .can_move_o       (can_move_o),
      .move_x_o         (move_x_o),
      .move_y_o         (move_y_o)
   );

   task automatic check(input string tag, input int obs, input int exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [ER*EC-1:0] walls_only();
      logic [ER*EC-1:0] f;
      f = '0;
      for (int r = 0; r < ER; r++) begin
         f[r*EC]        = 1'b1;
         f[r*EC+EC-1]   = 1'b1;
      end
      for (int c = 0; c < EC; c++) f[(ER-1)*EC+c] = 1'b1;
      return f;
   endfunction

   // Reference: walk the 16 mask cells of the candidate and apply the placement rules directly.
   function automatic void model(input logic [2:0] mv, input logic [63:0] data, input int rot,
                                 input int x, input int y, input logic [ER*EC-1:0] fld,
                                 output int can, output int dx, output int dy);
      int r, row, col;
      logic [15:0] mask;
      dx = 0; dy = 0; r = rot;
      case (mv)
         3'd0: dx = -1;
         3'd1: dx = 1;
         3'd3: r = (rot + 1) % 4;
         3'd4: ;
         default: dy = 1;
      endcase
      mask = data[63-16*r -: 16];
      can = 1;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (mask[15-(4*i+j)]) begin
               row = y + dy + i;
               col = x + dx + j;
               if (col < 0 || col >= EC || row >= ER) can = 0;
               else if (row >= 0 && fld[row*EC+col]) can = 0;
            end
         end
      end
   endfunction

   task automatic start_run(input logic [2:0] mv, input logic [63:0] data, input int rot,
                            input int x, input int y);
      @(negedge clk_i);
      run_i            = 1'b1;
      req_move_i       = mv;
      block_i_data     = data;
      block_i_rotation = rot[1:0];
      block_i_x        = x[X_W-1:0];
      block_i_y        = y[Y_W-1:0];
      @(posedge clk_i);
      #1;
      run_i            = 1'b0;
      req_move_i       = 3'($urandom);
      block_i_data     = {$urandom, $urandom};
      block_i_rotation = 2'($urandom);
      block_i_x        = X_W'($urandom);
      block_i_y        = Y_W'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk_i);
         #1;
         if (done_o) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int lat, input int ecan,
                               input int edx, input int edy);
      check({tag, ".latency"}, lat, LAT);
      check({tag, ".can"},     int'(can_move_o), ecan);
      check({tag, ".dx"},      int'(move_x_o), edx);
      check({tag, ".dy"},      int'(move_y_o), edy);
   endtask

   task automatic run_and_check(input string tag, input logic [2:0] mv, input logic [63:0] data,
                                input int rot, input int x, input int y);
      int ecan, edx, edy, lat;
      model(mv, data, rot, x, y, field, ecan, edx, edy);
      start_run(mv, data, rot, x, y);
      wait_done(lat);
      check_result(tag, lat, ecan, edx, edy);
      @(posedge clk_i);
      #1;
      check({tag, ".done_pulse"}, int'(done_o), 0);
      check({tag, ".can_hold"},   int'(can_move_o), ecan);
   endtask

   localparam logic [63:0] O_PIECE = {4{16'h0660}};
   localparam logic [63:0] I_HORZ  = {4{16'h0F00}};
   localparam logic [63:0] ROT_SET = {16'h2222, 16'h0F00, 16'h4444, 16'h00F0};
   localparam logic [63:0] APPEAR_P = {4{16'hF660}};

   initial begin
      int lat, extra, ecan, edx, edy;
      logic [63:0] d;
      rst_n_i = 1'b1; run_i = 1'b0; req_move_i = '0; block_i_data = '0;
      block_i_rotation = '0; block_i_x = '0; block_i_y = '0;
      field = walls_only();
      #2 rst_n_i = 1'b0;
      #1;
      check("reset.done", int'(done_o), 0);
      check("reset.can",  int'(can_move_o), 0);
      check("reset.dx",   int'(move_x_o), 0);
      check("reset.dy",   int'(move_y_o), 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_n_i = 1'b1;

      run_and_check("o_left",     3'd0, O_PIECE, 0, 4, 1);
      check("o_left.model_can", int'(can_move_o), 1);
      run_and_check("i_wall",     3'd0, I_HORZ, 0, 1, 5);
      run_and_check("i_right",    3'd1, I_HORZ, 0, 1, 5);
      run_and_check("o_floor",    3'd2, O_PIECE, 0, 4, 18);
      field[20*EC+5] = 1'b1;
      run_and_check("o_stack",    3'd2, O_PIECE, 0, 4, 17);
      field = walls_only();
      field[7*EC+6] = 1'b1;
      run_and_check("rot_block",  3'd3, ROT_SET, 3, 4, 5);
      field = walls_only();
      run_and_check("rot_free",   3'd3, ROT_SET, 3, 4, 5);
      run_and_check("appear_ok",  3'd4, APPEAR_P, 0, 4, -1);
      field[0*EC+5] = 1'b1;
      run_and_check("appear_hit", 3'd4, APPEAR_P, 0, 4, -1);
      field = walls_only();
      run_and_check("code7_down", 3'd7, O_PIECE, 0, 4, 1);
      run_and_check("empty_mask", 3'd0, 64'd0, 0, -8, 30);

      // Restart two cycles into a check: one done, timed from the second run, with its delta.
      start_run(3'd0, O_PIECE, 0, 4, 1);
      @(posedge clk_i);
      model(3'd1, I_HORZ, 0, 1, 5, field, ecan, edx, edy);
      start_run(3'd1, I_HORZ, 0, 1, 5);
      wait_done(lat);
      check_result("abort", lat, ecan, edx, edy);
      extra = 0;
      repeat (8) begin
         @(posedge clk_i);
         #1;
         if (done_o) extra++;
      end
      check("abort.extra_done", extra, 0);

      // New run captured on the edge that ends the done cycle.
      start_run(3'd2, O_PIECE, 0, 4, 18);
      wait_done(lat);
      check_result("back2back.first", lat, 0, 0, 1);
      start_run(3'd0, O_PIECE, 0, 4, 1);
      wait_done(lat);
      check_result("back2back.second", lat, 1, -1, 0);

      // Reset in the middle of a scan.
      run_and_check("pre_rst", 3'd2, O_PIECE, 0, 4, 1);
      start_run(3'd1, I_HORZ, 0, 1, 5);
      @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      #1;
      check("mid_rst.done", int'(done_o), 0);
      check("mid_rst.can",  int'(can_move_o), 0);
      check("mid_rst.dx",   int'(move_x_o), 0);
      check("mid_rst.dy",   int'(move_y_o), 0);
      @(negedge clk_i) rst_n_i = 1'b1;
      extra = 0;
      repeat (8) begin
         @(posedge clk_i);
         #1;
         if (done_o) extra++;
      end
      check("mid_rst.no_done", extra, 0);

      for (int n = 0; n < 40; n++) begin
         field = walls_only();
         for (int r = 0; r < ER-1; r++)
            for (int c = 1; c < EC-1; c++)
               if ($urandom_range(5) == 0) field[r*EC+c] = 1'b1;
         d = {$urandom, $urandom};
         if (n % 2 == 1) d = d & {$urandom, $urandom};
         run_and_check($sformatf("rand%0d", n), 3'($urandom), d, int'($urandom_range(3)),
                       int'($urandom_range(13)) - 2, int'($urandom_range(23)) - 3);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
